// File: rtl/cnn_mem_pkg.sv
// Shared constants and state encoding for the line-memory serializer.
package cnn_mem_pkg;

  localparam int DW_DEF       = 16;
  localparam int MEM_SIZE_DEF = 10;
  localparam int MEM_ADDR_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Word 0 sits in the most significant slot of a packed line.
  function automatic int word_msb(int k, int words, int dw);
    return (words - k) * dw - 1;
  endfunction

endpackage

// File: rtl/line_serializer.sv
// Serializes one parallel line into MEM_SIZE sequential memory writes.
// Build option LINE_SERIALIZER_READBACK_EN adds a FLUSH state issuing a one-cycle rd_en with done.
module line_serializer
  import cnn_mem_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int MEM_SIZE = MEM_SIZE_DEF,
  parameter int MEM_ADDR = MEM_ADDR_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [MEM_SIZE*DW-1:0] line_in,
  input  logic                   line_valid,
  output logic                   line_ready,
  input  logic                   hold,
  output logic [DW-1:0]          wr_data,
  output logic [MEM_ADDR-1:0]    wr_add,
  output logic                   wr_en,
  output logic                   rd_en,
  output logic                   busy,
  output logic                   done
);

  localparam int LW = $clog2(MEM_SIZE * DW);
  localparam logic [MEM_ADDR-1:0] LAST_ADDR = MEM_ADDR'(MEM_SIZE - 1);

  if ((2 ** MEM_ADDR) < MEM_SIZE) begin : g_bad_addr_width
    $error("MEM_ADDR too narrow for MEM_SIZE");
  end

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [MEM_ADDR-1:0]    r_cnt;
  logic [MEM_ADDR-1:0]    w_cnt_nxt;
  logic [MEM_SIZE*DW-1:0] r_line;
  logic [LW-1:0]          w_msb;
  logic [DW-1:0]          w_word;
  logic                   w_accept;
`ifndef LINE_SERIALIZER_READBACK_EN
  // Marks the extra SEND cycle that carries done once the last word is out.
  logic                   r_last;
  logic                   w_last_nxt;
`endif

  assign w_accept = (r_state == ST_IDLE) && line_valid;
  assign w_msb    = LW'(word_msb(int'(r_cnt), MEM_SIZE, DW));
  assign w_word   = r_line[w_msb -: DW];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_line  <= '0;
`ifndef LINE_SERIALIZER_READBACK_EN
      r_last  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_line <= line_in;
      end
`ifndef LINE_SERIALIZER_READBACK_EN
      r_last  <= w_last_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
`ifndef LINE_SERIALIZER_READBACK_EN
    w_last_nxt  = r_last;
`endif
    line_ready  = 1'b0;
    busy        = 1'b1;
    wr_en       = 1'b0;
    wr_add      = '0;
    wr_data     = '0;
    rd_en       = 1'b0;
    done        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        line_ready = 1'b1;
        busy       = 1'b0;
        if (w_accept) begin
          w_state_nxt = ST_SEND;
          w_cnt_nxt   = '0;
        end
      end

      ST_SEND: begin
`ifndef LINE_SERIALIZER_READBACK_EN
        if (r_last) begin
          done        = 1'b1;
          w_last_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end else begin
`else
        begin
`endif
          // Address and data stay on the current word while stalled.
          wr_add  = r_cnt;
          wr_data = w_word;
          wr_en   = !hold;
          if (!hold) begin
            if (r_cnt == LAST_ADDR) begin
              w_cnt_nxt   = '0;
`ifdef LINE_SERIALIZER_READBACK_EN
              w_state_nxt = ST_FLUSH;
`else
              w_last_nxt  = 1'b1;
`endif
            end else begin
              w_cnt_nxt = r_cnt + MEM_ADDR'(1);
            end
          end
        end
      end

`ifdef LINE_SERIALIZER_READBACK_EN
      ST_FLUSH: begin
        rd_en       = 1'b1;
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
`endif

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Outputs read as idle for the whole time reset is held.
    if (reset) begin
      line_ready = 1'b1;
      busy       = 1'b0;
      wr_en      = 1'b0;
      wr_add     = '0;
      wr_data    = '0;
      rd_en      = 1'b0;
      done       = 1'b0;
    end
  end

endmodule

// File: tb/tb_line_serializer.sv
// Scoreboard bench for line_serializer: driver models word order and hold, monitor compares outputs.
module tb_line_serializer;

  localparam int DW = 16;
  localparam int MS = 10;
  localparam int MA = 4;

  typedef logic [DW-1:0] line_t [MS];
  typedef struct {
    logic [MA-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [MS*DW-1:0] line_in;
  logic           line_valid;
  logic           line_ready;
  logic           hold;
  logic [DW-1:0]  wr_data;
  logic [MA-1:0]  wr_add;
  logic           wr_en;
  logic           rd_en;
  logic           busy;
  logic           done;

  line_serializer #(.DW(DW), .MEM_SIZE(MS), .MEM_ADDR(MA)) dut (
    .clk(clk), .reset(reset), .line_in(line_in), .line_valid(line_valid),
    .line_ready(line_ready), .hold(hold), .wr_data(wr_data), .wr_add(wr_add),
    .wr_en(wr_en), .rd_en(rd_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  wr_t wq[$];
  int  dq[$];
  bit  mon_on = 1'b0;
  bit  exp_ready, exp_hold, exp_rst;
  logic [MA-1:0] frz_a;
  logic [DW-1:0] frz_d;
  int  total = 0;
  int  bad = 0;
  wr_t e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (wr_en === 1'b1) begin
        if (wq.size() == 0) chk("unexpected_wr", 32'd1, 32'd0);
        else begin
          e = wq.pop_front();
          chk("wr_add", 32'(wr_add), 32'(e.a));
          chk("wr_data", 32'(wr_data), 32'(e.d));
        end
      end else if (exp_hold) begin
        chk("hold_add", 32'(wr_add), 32'(frz_a));
        chk("hold_data", 32'(wr_data), 32'(frz_d));
      end else begin
        chk("idle_add", 32'(wr_add), 32'd0);
        chk("idle_data", 32'(wr_data), 32'd0);
      end
      if (exp_hold) chk("hold_wr_en", 32'(wr_en), 32'd0);
      if (done === 1'b1) begin
        if (dq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else chk("done_cycle", 32'(cyc), 32'(dq.pop_front()));
      end
`ifdef LINE_SERIALIZER_READBACK_EN
      chk("rd_en_with_done", 32'(rd_en), 32'(done));
`else
      chk("rd_en_zero", 32'(rd_en), 32'd0);
`endif
      chk("wr_rd_overlap", 32'(wr_en & rd_en), 32'd0);
      chk("line_ready", 32'(line_ready), 32'(exp_ready));
      chk("busy", 32'(busy), 32'(!exp_ready));
      if (exp_rst) begin
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MS*DW-1:0] pack(input line_t w);
    logic [MS*DW-1:0] p;
    p = '0;
    for (int k = 0; k < MS; k++) p[(MS-k)*DW-1 -: DW] = w[k];
    return p;
  endfunction

  function automatic line_t rand_line();
    line_t w;
    for (int k = 0; k < MS; k++) w[k] = DW'($urandom);
    return w;
  endfunction

  task automatic idle(input int n);
    line_valid = 1'b0;
    exp_ready  = 1'b1;
    exp_hold   = 1'b0;
    for (int i = 0; i < n; i++) begin
      hold = 1'($urandom_range(1));
      step();
    end
  endtask

  // One accepted line: writes advance only on hold=0 cycles, done one cycle after the last write.
  task automatic send_line(input line_t w, input int hold_pct, input bit keep_valid,
                           input logic [MS*DW-1:0] nxt, input int rst_at,
                           input int hold_at, input int hold_len);
    int  k;
    int  hcnt;
    bit  h;
    wr_t x;
    line_valid = 1'b1;
    line_in    = pack(w);
    exp_ready  = 1'b1;
    exp_hold   = 1'b0;
    hold       = 1'($urandom_range(1));
    step();
    k = 0;
    hcnt = 0;
    while (k < MS) begin
      exp_ready = 1'b0;
      if (keep_valid) begin
        line_valid = 1'b1;
        line_in    = nxt;
      end else begin
        line_valid = 1'($urandom_range(1));
        line_in    = pack(rand_line());
      end
      if (k == rst_at) begin
        reset      = 1'b1;
        hold       = 1'b0;
        line_valid = 1'b0;
        exp_rst    = 1'b1;
        exp_ready  = 1'b1;
        exp_hold   = 1'b0;
        step();
        reset   = 1'b0;
        exp_rst = 1'b0;
        return;
      end
      if (k == hold_at && hcnt < hold_len) begin
        h = 1'b1;
        hcnt++;
      end else begin
        h = ($urandom_range(99) < hold_pct);
      end
      hold = h;
      if (h) begin
        exp_hold = 1'b1;
        frz_a    = MA'(k);
        frz_d    = w[k];
      end else begin
        exp_hold = 1'b0;
        x.a = MA'(k);
        x.d = w[k];
        wq.push_back(x);
        k++;
      end
      step();
    end
    exp_hold  = 1'b0;
    exp_ready = 1'b0;
    hold      = 1'($urandom_range(1));
    dq.push_back(cyc);
    step();
  endtask

  initial begin
    line_t wa, wb, cur, nx;
    bit kv;
    reset      = 1'b1;
    line_valid = 1'b0;
    hold       = 1'b0;
    line_in    = '0;
    exp_rst    = 1'b1;
    exp_ready  = 1'b1;
    exp_hold   = 1'b0;
    frz_a      = '0;
    frz_d      = '0;
    step();
    step();
    mon_on = 1'b1;
    line_valid = 1'b1;
    line_in = pack(rand_line());
    step();
    reset   = 1'b0;
    exp_rst = 1'b0;
    idle(2);

    for (int k = 0; k < MS; k++) wa[k] = DW'(k + 1);
    send_line(wa, 0, 1'b0, '0, -1, -1, 0);
    idle(2);
    send_line(wa, 0, 1'b0, '0, -1, 4, 3);
    idle(1);

    wa = rand_line();
    wb = rand_line();
    send_line(wa, 0, 1'b1, pack(wb), -1, -1, 0);
    send_line(wb, 0, 1'b0, '0, -1, -1, 0);
    idle(2);

    send_line(rand_line(), 0, 1'b0, '0, 6, -1, 0);
    idle(2);

    cur = rand_line();
    for (int n = 0; n < 10; n++) begin
      nx = rand_line();
      kv = 1'($urandom_range(1));
      send_line(cur, 30, kv, pack(nx), -1, -1, 0);
      if (!kv) idle($urandom_range(2));
      cur = nx;
    end
    send_line(cur, 30, 1'b0, '0, 3 + $urandom_range(5), -1, 0);
    idle(3);

    chk("writes_pending", 32'(wq.size()), 32'd0);
    chk("dones_pending", 32'(dq.size()), 32'd0);
    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
